// File: rtl/alt_eyemon_phase_sweep.sv
// Eye-monitor phase sweep controller: walks a user-linear phase range, programs
// each point's CRAM code, settles, counts error pulses over a dwell and reports.
module alt_eyemon_phase_sweep #(
    parameter int PHASE_W       = 6,
    parameter int DWELL_W       = 16,
    parameter int ERR_W         = 24,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [PHASE_W-1:0] i_first,
    input  logic [PHASE_W-1:0] i_last,
    input  logic [PHASE_W-1:0] i_step,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_err,
    output logic               o_wr_req,
    output logic [PHASE_W-1:0] o_wr_code,
    input  logic               i_wr_ack,
    output logic               o_res_valid,
    output logic [PHASE_W-1:0] o_res_phase,
    output logic [ERR_W-1:0]   o_res_errs,
    input  logic               i_res_ready,
    output logic               o_busy,
    output logic               o_done,
    input  logic [PHASE_W-1:0] i_rd_code,
    output logic [PHASE_W-1:0] o_rd_user
);

    localparam int LOW_W = PHASE_W - 2;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]   SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;
    localparam logic [PHASE_W-1:0] STEP_ONE = PHASE_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROGRAM,
        S_SETTLE,
        S_DWELL,
        S_REPORT
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] cur;
    logic [PHASE_W-1:0] last_q;
    logic [PHASE_W-1:0] step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               dir_up;
    logic [SET_W-1:0]   settle_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [ERR_W-1:0]   acc;
    logic [ERR_W-1:0]   acc_next;
    logic [PHASE_W:0]   sum_up;
    logic [PHASE_W:0]   sum_dn;
    logic [PHASE_W-1:0] next_cur;
    logic               last_point;

    // Quadrants alternate direction, so Q-1-low is simply the inverted low field.
    function automatic logic [PHASE_W-1:0] fwd_map(input logic [PHASE_W-1:0] u);
        logic [LOW_W-1:0] ul;
        ul = u[LOW_W-1:0];
        case (u[PHASE_W-1 -: 2])
            2'd0:    fwd_map = {2'b11, ~ul};
            2'd1:    fwd_map = {2'b01, ul};
            2'd2:    fwd_map = {2'b00, ~ul};
            default: fwd_map = {2'b10, ul};
        endcase
    endfunction

    function automatic logic [PHASE_W-1:0] inv_map(input logic [PHASE_W-1:0] c);
        logic [LOW_W-1:0] cl;
        cl = c[LOW_W-1:0];
        case (c[PHASE_W-1 -: 2])
            2'b00:   inv_map = {2'b10, ~cl};
            2'b01:   inv_map = {2'b01, cl};
            2'b10:   inv_map = {2'b11, cl};
            default: inv_map = {2'b00, ~cl};
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] a);
        sat_inc = (a == ERR_MAX) ? a : a + 1'b1;
    endfunction

    assign acc_next = i_err ? sat_inc(acc) : acc;

    // One extra bit exposes both overflow past the top and underflow below zero.
    assign sum_up = {1'b0, cur} + {1'b0, step_q};
    assign sum_dn = {1'b0, cur} - {1'b0, step_q};

    always_comb begin
        last_point = 1'b0;
        next_cur   = cur;
        if (cur == last_q) begin
            last_point = 1'b1;
        end else if (dir_up) begin
            if (sum_up > {1'b0, last_q}) last_point = 1'b1;
            else next_cur = sum_up[PHASE_W-1:0];
        end else begin
            if (sum_dn[PHASE_W] || (sum_dn[PHASE_W-1:0] < last_q)) last_point = 1'b1;
            else next_cur = sum_dn[PHASE_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cur         <= '0;
            last_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dir_up      <= 1'b0;
            settle_cnt  <= '0;
            dwell_cnt   <= '0;
            acc         <= '0;
            o_wr_req    <= 1'b0;
            o_wr_code   <= '0;
            o_res_valid <= 1'b0;
            o_res_phase <= '0;
            o_res_errs  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_user   <= '0;
        end else begin
            o_rd_user <= inv_map(i_rd_code);
            o_done    <= 1'b0;
            if (i_abort) begin
                state       <= S_IDLE;
                o_wr_req    <= 1'b0;
                o_res_valid <= 1'b0;
                o_busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            cur       <= i_first;
                            last_q    <= i_last;
                            step_q    <= (i_step == '0) ? STEP_ONE : i_step;
                            dwell_q   <= (i_dwell == '0) ? DWELL_ONE : i_dwell;
                            dir_up    <= (i_first <= i_last);
                            o_wr_req  <= 1'b1;
                            o_wr_code <= fwd_map(i_first);
                            o_busy    <= 1'b1;
                            state     <= S_PROGRAM;
                        end
                    end
                    S_PROGRAM: begin
                        if (i_wr_ack) begin
                            o_wr_req   <= 1'b0;
                            settle_cnt <= '0;
                            dwell_cnt  <= '0;
                            acc        <= '0;
                            state      <= (SETTLE_CYCLES == 0) ? S_DWELL : S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SET_LAST) state <= S_DWELL;
                        else settle_cnt <= settle_cnt + 1'b1;
                    end
                    S_DWELL: begin
                        acc <= acc_next;
                        if (dwell_cnt == dwell_q - 1'b1) begin
                            o_res_valid <= 1'b1;
                            o_res_phase <= cur;
                            o_res_errs  <= acc_next;
                            state       <= S_REPORT;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        if (i_res_ready) begin
                            o_res_valid <= 1'b0;
                            if (last_point) begin
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= S_IDLE;
                            end else begin
                                cur       <= next_cur;
                                o_wr_req  <= 1'b1;
                                o_wr_code <= fwd_map(next_cur);
                                state     <= S_PROGRAM;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
